// File: rtl/datapath_pkg.sv
// Shared encodings for the register/ALU/RAM datapath: command opcodes,
// ALU function codes, controller states and status flag bit positions.
// Pure definitions; no logic.
package datapath_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_ALU   = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    // ALU function select codes carried on FS; unlisted codes produce zero
    localparam logic [4:0] FS_AND    = 5'd0;
    localparam logic [4:0] FS_OR     = 5'd1;
    localparam logic [4:0] FS_XOR    = 5'd2;
    localparam logic [4:0] FS_ADD    = 5'd3;
    localparam logic [4:0] FS_SUB    = 5'd4;
    localparam logic [4:0] FS_SHL    = 5'd5;
    localparam logic [4:0] FS_SHR    = 5'd6;
    localparam logic [4:0] FS_PASS_B = 5'd7;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Bit positions inside the 4-bit {V,C,N,Z} status word
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_param.sv
// Parameterised ALU: logic ops, add/sub with carry/overflow, logical shifts, pass-B.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module alu_param
    import datapath_pkg::*;
#(
    parameter int WIDTH = 64
)(
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FS,
    output logic [WIDTH-1:0] F,
    output logic [3:0]       flags
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [31:0]    sh_amt;
    logic           carry;
    logic           ovf;

    // Subtraction as A + ~B + 1 so the top bit is the not-borrow carry
    assign sum    = {1'b0, A} + {1'b0, B};
    assign diff   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign sh_amt = 32'(B[5:0]) % 32'(WIDTH);

    // Function decode and flag generation
    always_comb begin
        F     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (FS)
            FS_AND:    F = A & B;
            FS_OR:     F = A | B;
            FS_XOR:    F = A ^ B;
            FS_ADD: begin
                F     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            FS_SUB: begin
                F     = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            FS_SHL:    F = A << sh_amt;
            FS_SHR:    F = A >> sh_amt;
            FS_PASS_B: F = B;
            default:   F = '0;
        endcase
        flags         = '0;
        flags[FLAG_Z] = (F == '0);
        flags[FLAG_N] = F[WIDTH-1];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/datapath_reg_alu_mem.sv
// Multi-cycle datapath: register file, ALU and word RAM executing one command at a time.
// Latency: ALU/NOP 2 cycles, STORE 3, LOAD 4 from accept to done.
// Backpressure: cmd_ready only in IDLE; cmd_valid offered in other states is ignored.
module datapath_reg_alu_mem
    import datapath_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int NREG  = 32,
    parameter  int DEPTH = 256,
    localparam int RW    = $clog2(NREG),
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [RW-1:0]    DA,
    input  logic [RW-1:0]    SA,
    input  logic [RW-1:0]    SB,
    input  logic [WIDTH-1:0] K,
    input  logic             BS,
    input  logic [4:0]       FS,
    output logic             done,
    output logic [WIDTH-1:0] data,
    output logic [3:0]       status,
    output logic             err
);

    // Highest register is hardwired to zero
    localparam logic [RW-1:0] REG_ZERO = RW'(NREG - 1);

    state_t           state;
    logic [1:0]       op_q;
    logic [RW-1:0]    da_q;
    logic [RW-1:0]    sa_q;
    logic [RW-1:0]    sb_q;
    logic [WIDTH-1:0] k_q;
    logic             bs_q;
    logic [4:0]       fs_q;
    logic [AW-1:0]    addr_q;
    logic             oor_q;

    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] ram_q;

    logic [WIDTH-1:0] rd_sa;
    logic [WIDTH-1:0] rd_sb;
    logic [WIDTH-1:0] rd_da;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_f;
    logic [3:0]       alu_flags;
    logic             reg_we;
    logic [WIDTH-1:0] reg_wd;

    assign cmd_ready = (state == ST_IDLE);

    assign rd_sa = (sa_q == REG_ZERO) ? '0 : regs[sa_q];
    assign rd_sb = (sb_q == REG_ZERO) ? '0 : regs[sb_q];
    assign rd_da = (da_q == REG_ZERO) ? '0 : regs[da_q];
    assign alu_b = bs_q ? k_q : rd_sb;

    // Register writeback: ALU result at end of EXEC, RAM data at end of WB
    assign reg_we = ((state == ST_EXEC) && (op_q == OP_ALU)) ||
                    ((state == ST_WB) && !oor_q);
    assign reg_wd = (state == ST_WB) ? ram_q : alu_f;

    alu_param #(.WIDTH(WIDTH)) u_alu (
        .A     (rd_sa),
        .B     (alu_b),
        .FS    (fs_q),
        .F     (alu_f),
        .flags (alu_flags)
    );

    // Command sequencing, captured fields, done/err pulses, status and data outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= ST_IDLE;
            done   <= 1'b0;
            err    <= 1'b0;
            status <= '0;
            data   <= '0;
            op_q   <= OP_NOP;
            da_q   <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
            k_q    <= '0;
            bs_q   <= 1'b0;
            fs_q   <= '0;
            addr_q <= '0;
            oor_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (reg_we) begin
                data <= reg_wd;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        da_q  <= DA;
                        sa_q  <= SA;
                        sb_q  <= SB;
                        k_q   <= K;
                        bs_q  <= BS;
                        fs_q  <= FS;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
                        addr_q <= alu_f[AW-1:0];
                        oor_q  <= |alu_f[WIDTH-1:AW];
                        state  <= ST_MEM;
                    end else begin
                        if (op_q == OP_ALU) begin
                            status <= alu_flags;
                        end
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_MEM: begin
                    if (op_q == OP_LOAD) begin
                        state <= ST_WB;
                    end else begin
                        done  <= 1'b1;
                        err   <= oor_q;
                        state <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    done  <= 1'b1;
                    err   <= oor_q;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register file; writes to the zero register are dropped
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we && (da_q != REG_ZERO)) begin
            regs[da_q] <= reg_wd;
        end
    end

    // RAM keeps its contents through reset; an asserted reset also blocks a pending store
    always_ff @(posedge clock) begin
        if (reset && (state == ST_MEM)) begin
            if ((op_q == OP_STORE) && !oor_q) begin
                mem[addr_q] <= rd_da;
            end
            ram_q <= mem[addr_q];
        end
    end

endmodule

// File: tb/tb_datapath_reg_alu_mem.sv
// Scoreboard bench for datapath_reg_alu_mem with default parameters.
// A reference model predicts every command's result into a queue when it is issued.
// Each test pops the prediction when done is seen and compares it inline.
module tb_datapath_reg_alu_mem;
    import datapath_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  DA, SA, SB;
    logic [63:0] K;
    logic        BS;
    logic [4:0]  FS;
    logic        done;
    logic [63:0] data;
    logic [3:0]  status;
    logic        err;

    always #5 clock = ~clock;

    datapath_reg_alu_mem dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .DA(DA), .SA(SA), .SB(SB), .K(K), .BS(BS), .FS(FS),
        .done(done), .data(data), .status(status), .err(err)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  da, sa, sb;
        logic [63:0] k;
        logic        bs;
        logic [4:0]  fs;
    } cmd_t;

    typedef struct packed {
        logic [7:0]  lat;
        logic [63:0] data;
        logic [3:0]  status;
        logic        err;
    } res_t;

    res_t        exp_q[$];
    logic [63:0] m_reg [32];
    logic [63:0] m_mem [int];
    logic [63:0] m_data;
    logic [3:0]  m_status;
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic cmd_t mk(input logic [1:0] op, input logic [4:0] da, sa, sb,
                                input logic [63:0] k, input logic bs, input logic [4:0] fs);
        cmd_t c;
        c.op = op; c.da = da; c.sa = sa; c.sb = sb; c.k = k; c.bs = bs; c.fs = fs;
        return c;
    endfunction

    function automatic logic [63:0] m_rd(input logic [4:0] idx);
        return (idx == 5'd31) ? 64'd0 : m_reg[idx];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 64'd0;
        m_data   = 64'd0;
        m_status = 4'd0;
    endfunction

    // Reference ALU: overflow from 66-bit signed arithmetic, SUB carry as unsigned a >= b
    function automatic void alu_ref(input logic [4:0] fs, input logic [63:0] a, b,
                                    output logic [63:0] f, output logic [3:0] fl);
        logic [65:0] s;
        logic        c, v;
        c = 1'b0; v = 1'b0; f = 64'd0;
        case (fs)
            5'd0: f = a & b;
            5'd1: f = a | b;
            5'd2: f = a ^ b;
            5'd3: begin
                s = {{2{a[63]}}, a} + {{2{b[63]}}, b};
                f = s[63:0];
                c = ({1'b0, a} + {1'b0, b}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
                v = s[64] != s[63];
            end
            5'd4: begin
                s = {{2{a[63]}}, a} - {{2{b[63]}}, b};
                f = s[63:0];
                c = (a >= b);
                v = s[64] != s[63];
            end
            5'd5: f = a << b[5:0];
            5'd6: f = a >> b[5:0];
            5'd7: f = b;
            default: f = 64'd0;
        endcase
        fl = {v, c, f[63], (f == 64'd0)};
    endfunction

    function automatic res_t predict(input cmd_t c);
        res_t        r;
        logic [63:0] a, b, f, val;
        logic [3:0]  fl;
        logic        bad;
        int          adr;
        a   = m_rd(c.sa);
        b   = c.bs ? c.k : m_rd(c.sb);
        alu_ref(c.fs, a, b, f, fl);
        bad = (f[63:8] != 56'd0);
        adr = int'(f[7:0]);
        r.err = 1'b0;
        case (c.op)
            OP_ALU: begin
                r.lat = 8'd2;
                if (c.da != 5'd31) m_reg[c.da] = f;
                m_data = f; m_status = fl;
            end
            OP_LOAD: begin
                r.lat = 8'd4; r.err = bad;
                if (!bad) begin
                    val = m_mem.exists(adr) ? m_mem[adr] : 64'd0;
                    if (c.da != 5'd31) m_reg[c.da] = val;
                    m_data = val;
                end
            end
            OP_STORE: begin
                r.lat = 8'd3; r.err = bad;
                if (!bad) m_mem[adr] = m_rd(c.da);
            end
            default: r.lat = 8'd2;
        endcase
        r.data = m_data; r.status = m_status;
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    // With garble set, junk commands are offered on every busy cycle.
    task automatic issue(input cmd_t c, input bit garble, output res_t obs);
        exp_q.push_back(predict(c));
        obs = '0;
        obs.lat = 8'hFF;
        cmd_valid = 1'b1; cmd_op = c.op; DA = c.da; SA = c.sa; SB = c.sb;
        K = c.k; BS = c.bs; FS = c.fs;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clock);
            if (done) begin
                obs.lat = 8'(cyc); obs.data = data; obs.status = status; obs.err = err;
                break;
            end
            if (garble) begin
                cmd_valid = 1'b1; cmd_op = 2'($urandom); DA = 5'($urandom);
                SA = 5'($urandom); SB = 5'($urandom); K = {$urandom, $urandom};
                BS = 1'($urandom); FS = 5'($urandom);
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; DA = '0; SA = '0; SB = '0;
        K = '0; BS = 1'b0; FS = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_total++; if (data !== 64'd0) $display("FAIL reset_data: got %h want 0", data); else n_pass++;
        n_total++; if (status !== 4'd0) $display("FAIL reset_status: got %b want 0000", status); else n_pass++;
    endtask

    task automatic test_add();
        res_t o, e;
        issue(mk(OP_ALU, 5'd1, 5'd0, 5'd0, 64'd5, 1'b1, FS_ADD), 1'b0, o);
        e = exp_q.pop_front();
        n_total++; if (o !== e) $display("FAIL add: got %0d/%h/%b/%b want %0d/%h/%b/%b", o.lat, o.data, o.status, o.err, e.lat, e.data, e.status, e.err); else n_pass++;
        n_total++; if ({o.lat, o.data, o.status} !== {8'd2, 64'd5, 4'b0000}) $display("FAIL add_vector: got lat %0d data %h st %b want 2/5/0000", o.lat, o.data, o.status); else n_pass++;
        @(negedge clock);
        n_total++; if (done !== 1'b0) $display("FAIL done_single_pulse: got %b want 0", done); else n_pass++;
    endtask

    task automatic test_alu_flags();
        res_t o, e;
        cmd_t tbl [4];
        logic [67:0] want [4];
        tbl[0] = mk(OP_ALU,   5'd3, 5'd31, 5'd0, 64'd7, 1'b1, FS_ADD);
        tbl[1] = mk(OP_ALU,   5'd5, 5'd3,  5'd3, 64'd0, 1'b0, FS_SUB);
        tbl[2] = mk(OP_ALU,   5'd4, 5'd0,  5'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, FS_PASS_B);
        tbl[3] = mk(OP_ALU,   5'd6, 5'd4,  5'd0, 64'd1, 1'b1, FS_ADD);
        want[0] = {64'd7, 4'b0000};
        want[1] = {64'd0, 4'b0101};
        want[2] = {64'h7FFF_FFFF_FFFF_FFFF, 4'b0000};
        want[3] = {64'h8000_0000_0000_0000, 4'b1010};
        for (int i = 0; i < 4; i++) begin
            issue(tbl[i], 1'b0, o);
            e = exp_q.pop_front();
            n_total++; if (o !== e) $display("FAIL flags_model[%0d]: got %0d/%h/%b want %0d/%h/%b", i, o.lat, o.data, o.status, e.lat, e.data, e.status); else n_pass++;
            n_total++; if ({o.data, o.status} !== want[i]) $display("FAIL flags_vector[%0d]: got %h/%b want %h", i, o.data, o.status, want[i]); else n_pass++;
        end
        // Every function code (plus two unused ones) against a random B
        for (int f = 0; f < 10; f++) begin
            issue(mk(OP_ALU, 5'd7, 5'd4, 5'd0, {$urandom, $urandom}, 1'b1, 5'(f)), 1'b0, o);
            e = exp_q.pop_front();
            n_total++; if (o !== e) $display("FAIL fs_%0d: got %h/%b want %h/%b", f, o.data, o.status, e.data, e.status); else n_pass++;
        end
    endtask

    task automatic test_store_load();
        res_t o, e;
        cmd_t tbl [3];
        logic [7:0] lat_w [3];
        tbl[0] = mk(OP_STORE, 5'd1, 5'd31, 5'd0, 64'h10, 1'b1, FS_ADD);
        tbl[1] = mk(OP_LOAD,  5'd2, 5'd31, 5'd0, 64'h10, 1'b1, FS_ADD);
        tbl[2] = mk(OP_ALU,   5'd8, 5'd0,  5'd2, 64'd0,  1'b0, FS_PASS_B);
        lat_w[0] = 8'd3; lat_w[1] = 8'd4; lat_w[2] = 8'd2;
        for (int i = 0; i < 3; i++) begin
            issue(tbl[i], 1'b0, o);
            e = exp_q.pop_front();
            n_total++; if (o !== e) $display("FAIL store_load[%0d]: got %0d/%h/%b/%b want %0d/%h/%b/%b", i, o.lat, o.data, o.status, o.err, e.lat, e.data, e.status, e.err); else n_pass++;
            n_total++; if (o.lat !== lat_w[i]) $display("FAIL store_load_latency[%0d]: got %0d want %0d", i, o.lat, lat_w[i]); else n_pass++;
        end
        n_total++; if (o.data !== 64'd5) $display("FAIL load_value: got %h want 5", o.data); else n_pass++;
    endtask

    task automatic test_out_of_range();
        res_t o, e;
        cmd_t tbl [4];
        tbl[0] = mk(OP_LOAD,  5'd2, 5'd31, 5'd0, 64'h100, 1'b1, FS_ADD);
        tbl[1] = mk(OP_ALU,   5'd9, 5'd0,  5'd2, 64'd0,   1'b0, FS_PASS_B);
        tbl[2] = mk(OP_STORE, 5'd3, 5'd31, 5'd0, 64'h110, 1'b1, FS_ADD);
        tbl[3] = mk(OP_LOAD,  5'd7, 5'd31, 5'd0, 64'h10,  1'b1, FS_ADD);
        for (int i = 0; i < 4; i++) begin
            issue(tbl[i], 1'b0, o);
            e = exp_q.pop_front();
            n_total++; if (o !== e) $display("FAIL oor[%0d]: got %0d/%h/%b/%b want %0d/%h/%b/%b", i, o.lat, o.data, o.status, o.err, e.lat, e.data, e.status, e.err); else n_pass++;
            if (i == 0) begin
                n_total++; if ({o.lat, o.err} !== {8'd4, 1'b1}) $display("FAIL oor_load_err: got lat %0d err %b want 4/1", o.lat, o.err); else n_pass++;
            end
            if (i == 3) begin
                n_total++; if (o.data !== 64'd5) $display("FAIL oor_ram_unchanged: got %h want 5", o.data); else n_pass++;
            end
        end
    endtask

    task automatic test_zero_reg();
        res_t o, e;
        issue(mk(OP_ALU, 5'd31, 5'd31, 5'd0, 64'd9, 1'b1, FS_ADD), 1'b0, o);
        e = exp_q.pop_front();
        n_total++; if (o.data !== 64'd9) $display("FAIL r31_data: got %h want 9", o.data); else n_pass++;
        n_total++; if (o !== e) $display("FAIL r31_write: got %h/%b want %h/%b", o.data, o.status, e.data, e.status); else n_pass++;
        issue(mk(OP_ALU, 5'd8, 5'd0, 5'd31, 64'd0, 1'b0, FS_PASS_B), 1'b0, o);
        e = exp_q.pop_front();
        n_total++; if ({o.data, o.status} !== {64'd0, 4'b0001}) $display("FAIL r31_read: got %h/%b want 0/0001", o.data, o.status); else n_pass++;
        n_total++; if (o !== e) $display("FAIL r31_read_model: got %h want %h", o.data, e.data); else n_pass++;
    endtask

    task automatic test_hold_valid();
        res_t o, e;
        cmd_t tbl [3];
        tbl[0] = mk(OP_ALU,   5'd9,  5'd1,  5'd0, 64'd100, 1'b1, FS_ADD);
        tbl[1] = mk(OP_STORE, 5'd9,  5'd31, 5'd0, 64'h30,  1'b1, FS_ADD);
        tbl[2] = mk(OP_LOAD,  5'd11, 5'd31, 5'd0, 64'h30,  1'b1, FS_ADD);
        for (int i = 0; i < 3; i++) begin
            issue(tbl[i], 1'b1, o);
            e = exp_q.pop_front();
            n_total++; if (o !== e) $display("FAIL hold_valid[%0d]: got %0d/%h/%b/%b want %0d/%h/%b/%b", i, o.lat, o.data, o.status, o.err, e.lat, e.data, e.status, e.err); else n_pass++;
        end
        n_total++; if (o.data !== 64'd105) $display("FAIL hold_valid_value: got %h want 105", o.data); else n_pass++;
    endtask

    task automatic test_reset_mid();
        res_t o, e;
        logic seen;
        // STORE R3 (=7) to 0x10 with cmd_valid left high; reset lands in MEM
        cmd_valid = 1'b1; cmd_op = OP_STORE; DA = 5'd3; SA = 5'd31; SB = 5'd0;
        K = 64'h10; BS = 1'b1; FS = FS_ADD;
        @(posedge clock);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", cmd_ready); else n_pass++;
        n_total++; if ({data, status} !== 68'd0) $display("FAIL abort_outputs: got %h/%b want 0/0000", data, status); else n_pass++;
        cmd_valid = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | done;
            @(negedge clock);
        end
        n_total++; if (seen !== 1'b0) $display("FAIL abort_no_done: got %b want 0", seen); else n_pass++;
        issue(mk(OP_LOAD, 5'd1, 5'd31, 5'd0, 64'h10, 1'b1, FS_ADD), 1'b0, o);
        e = exp_q.pop_front();
        n_total++; if (o.data !== 64'd5) $display("FAIL abort_ram_kept: got %h want 5", o.data); else n_pass++;
        n_total++; if (o !== e) $display("FAIL abort_load_model: got %0d/%h want %0d/%h", o.lat, o.data, e.lat, e.data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        res_t o, e;
        cmd_t c;
        int   r;
        for (int i = 0; i < 4; i++) begin
            issue(mk(OP_ALU, 5'(10 + i), 5'd0, 5'd0, {$urandom, $urandom}, 1'b1, FS_PASS_B), 1'b0, o);
            e = exp_q.pop_front();
            n_total++; if (o !== e) $display("FAIL b2b_init_reg[%0d]: got %h want %h", i, o.data, e.data); else n_pass++;
            issue(mk(OP_STORE, 5'(10 + i), 5'd31, 5'd0, 64'h20 + 64'(i), 1'b1, FS_ADD), 1'b0, o);
            e = exp_q.pop_front();
            n_total++; if (o !== e) $display("FAIL b2b_init_mem[%0d]: got %0d/%b want %0d/%b", i, o.lat, o.err, e.lat, e.err); else n_pass++;
        end
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            c = mk(OP_ALU, 5'($urandom), 5'($urandom), 5'($urandom), {$urandom, $urandom},
                   1'($urandom), 5'($urandom_range(0, 9)));
            if (r >= 5 && r <= 8) begin
                c.op = (r <= 6) ? OP_STORE : OP_LOAD;
                c.sa = 5'd31; c.bs = 1'b1; c.fs = FS_ADD;
                c.k  = ($urandom_range(0, 4) == 0) ? 64'h120 : 64'h20 + 64'($urandom_range(0, 3));
            end else if (r == 9) begin
                c.op = OP_NOP;
            end
            issue(c, 1'b0, o);
            e = exp_q.pop_front();
            n_total++; if (o !== e) $display("FAIL b2b[%0d] op %0d: got %0d/%h/%b/%b want %0d/%h/%b/%b", i, c.op, o.lat, o.data, o.status, o.err, e.lat, e.data, e.status, e.err); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_alu_flags();
        test_store_load();
        test_out_of_range();
        test_zero_reg();
        test_hold_valid();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
